regfile: RTL and testbench

- Register file built from per-entry write-enabled registers: 2**ADDR_W entries of WIDTH bits.
- One synchronous write port and two asynchronous (combinational) read ports.
- Entry 0 is hardwired to zero.
- Sits directly downstream of the single-register / 32-bit register / zero-register cells: it instantiates them with a write-address decoder and two read multiplexers, and feeds operands to the CPU datapath.

---
 rtl/regfile.sv | 126 ++++++++++++
 tb/tb_regfile.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/regfile.sv
// Register file: 2**ADDR_W entries of WIDTH bits, one synchronous write port,
// two combinational read ports, entry 0 hardwired to zero, optional write-through.

module regfile_cell #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_r;

  // Storage for one entry; reset takes priority over the write enable.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      q_r <= '0;
    end else if (en) begin
      q_r <= d;
    end else begin
      q_r <= q_r;
    end
  end

  assign q = q_r;

endmodule

module regfile_zero #(
  parameter int WIDTH = 32
) (
  output logic [WIDTH-1:0] q
);

  assign q = '0;

endmodule

module regfile #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5,
  parameter bit BYPASS = 1'b0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] WriteRegister,
  input  logic [WIDTH-1:0]  WriteData,
  input  logic [ADDR_W-1:0] ReadRegister1,
  input  logic [ADDR_W-1:0] ReadRegister2,
  output logic [WIDTH-1:0]  ReadData1,
  output logic [WIDTH-1:0]  ReadData2
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DEPTH-1:1] we_s;
  logic [WIDTH-1:0] entry_s [DEPTH];
  logic             hit1_s;
  logic             hit2_s;
  logic [WIDTH-1:0] rd1_s;
  logic [WIDTH-1:0] rd2_s;

  // One-hot write decoder; entry 0 has no enable at all.
  always_comb begin
    we_s = '0;
    for (int i = 1; i < DEPTH; i++) begin
      if (RegWrite && (WriteRegister == ADDR_W'(i))) begin
        we_s[i] = 1'b1;
      end else begin
        we_s[i] = 1'b0;
      end
    end
  end

  genvar g;
  generate
    for (g = 0; g < DEPTH; g++) begin : g_entry
      if (g == 0) begin : g_zero
        regfile_zero #(.WIDTH(WIDTH)) u_zero (
          .q (entry_s[g])
        );
      end else begin : g_reg
        regfile_cell #(.WIDTH(WIDTH)) u_cell (
          .clk     (clk),
          .reset_n (reset_n),
          .en      (we_s[g]),
          .d       (WriteData),
          .q       (entry_s[g])
        );
      end
    end
  endgenerate

  // Forwarding only applies to a write that will actually land this edge.
  assign hit1_s = BYPASS && reset_n && RegWrite &&
                  (ReadRegister1 == WriteRegister) && (ReadRegister1 != '0);
  assign hit2_s = BYPASS && reset_n && RegWrite &&
                  (ReadRegister2 == WriteRegister) && (ReadRegister2 != '0);

  // Read port 1 mux with optional write-through.
  always_comb begin
    rd1_s = '0;
    if (hit1_s) begin
      rd1_s = WriteData;
    end else begin
      rd1_s = entry_s[ReadRegister1];
    end
  end

  // Read port 2 mux with optional write-through.
  always_comb begin
    rd2_s = '0;
    if (hit2_s) begin
      rd2_s = WriteData;
    end else begin
      rd2_s = entry_s[ReadRegister2];
    end
  end

  assign ReadData1 = rd1_s;
  assign ReadData2 = rd2_s;

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench: a BYPASS=0 and a BYPASS=1 instance share stimulus and are
// compared against an array-based reference model.

module tb_regfile;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        RegWrite;
  logic [4:0]  WriteRegister;
  logic [31:0] WriteData;
  logic [4:0]  ReadRegister1;
  logic [4:0]  ReadRegister2;
  logic [31:0] rd1_b0, rd2_b0, rd1_b1, rd2_b1;

  logic [31:0] model [32];
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  regfile #(.WIDTH(32), .ADDR_W(5), .BYPASS(1'b0)) dut_b0 (
    .clk(clk), .reset_n(reset_n), .RegWrite(RegWrite),
    .WriteRegister(WriteRegister), .WriteData(WriteData),
    .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
    .ReadData1(rd1_b0), .ReadData2(rd2_b0)
  );

  regfile #(.WIDTH(32), .ADDR_W(5), .BYPASS(1'b1)) dut_b1 (
    .clk(clk), .reset_n(reset_n), .RegWrite(RegWrite),
    .WriteRegister(WriteRegister), .WriteData(WriteData),
    .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
    .ReadData1(rd1_b1), .ReadData2(rd2_b1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] expected_read(input logic [4:0] addr, input bit bypass);
    if (addr == 5'd0) return 32'h0;
    if (bypass && reset_n && RegWrite && (addr == WriteRegister)) return WriteData;
    return model[addr];
  endfunction

  // Compare all four read outputs against the model for the current inputs.
  task automatic check_all(input string tag);
    #1;
    check({tag, "/b0/rd1"}, rd1_b0, expected_read(ReadRegister1, 1'b0));
    check({tag, "/b0/rd2"}, rd2_b0, expected_read(ReadRegister2, 1'b0));
    check({tag, "/b1/rd1"}, rd1_b1, expected_read(ReadRegister1, 1'b1));
    check({tag, "/b1/rd2"}, rd2_b1, expected_read(ReadRegister2, 1'b1));
  endtask

  // One rising edge: update the model from the stable inputs, then step off the edge.
  task automatic tick();
    @(posedge clk);
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
    end else if (RegWrite && WriteRegister != 5'd0) begin
      model[WriteRegister] = WriteData;
    end
    #1;
  endtask

  task automatic write(input logic [4:0] a, input logic [31:0] d);
    reset_n = 1'b1; RegWrite = 1'b1; WriteRegister = a; WriteData = d;
    tick();
    RegWrite = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; RegWrite = 1'b0; WriteRegister = 5'd0; WriteData = 32'h0;
    ReadRegister1 = 5'd0; ReadRegister2 = 5'd0;
    for (int i = 0; i < 32; i++) model[i] = 32'hx;
    #2;
    tick();
    reset_n = 1'b1;
    ReadRegister1 = 5'd1; ReadRegister2 = 5'd31;
    check_all("reset_init");

    // Fill then reset: every address must read zero.
    for (int i = 1; i < 32; i++) write(5'(i), 32'hCC3B_82AA);
    ReadRegister1 = 5'd17;
    check_all("filled");
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    for (int a = 0; a < 32; a++) begin
      ReadRegister1 = 5'(a); ReadRegister2 = 5'(31 - a);
      #1;
      check("reset_rd1", rd1_b0, 32'h0);
      check("reset_rd2", rd2_b1, 32'h0);
    end

    write(5'd5, 32'hCC3B_82AA);
    ReadRegister1 = 5'd5; ReadRegister2 = 5'd6;
    #1;
    check("wr5_rd1", rd1_b0, 32'hCC3B_82AA);
    check("wr6_rd2", rd2_b0, 32'h0);

    // Walking ones, then read back every entry on both ports.
    for (int i = 1; i < 32; i++) write(5'(i), 32'h1 << i);
    for (int i = 1; i < 32; i++) begin
      ReadRegister1 = 5'(i); ReadRegister2 = 5'(i);
      #1;
      check("walk_rd1", rd1_b0, 32'h1 << i);
      check("walk_rd2", rd2_b1, 32'h1 << i);
    end

    write(5'd7, 32'h1234_5678);
    RegWrite = 1'b0; WriteRegister = 5'd7; WriteData = 32'hFFFF_FFFF;
    tick();
    ReadRegister1 = 5'd7;
    #1;
    check("en_off", rd1_b0, 32'h1234_5678);

    RegWrite = 1'b1; WriteRegister = 5'd0; WriteData = 32'hDEAD_BEEF;
    ReadRegister1 = 5'd0; ReadRegister2 = 5'd0;
    #1;
    check("zero_pre_b1", rd1_b1, 32'h0);
    tick();
    RegWrite = 1'b0;
    #1;
    check("zero_post_b0", rd1_b0, 32'h0);
    check("zero_post_b1", rd1_b1, 32'h0);

    write(5'd9, 32'h0000_00AA);
    RegWrite = 1'b1; WriteRegister = 5'd9; WriteData = 32'h0000_0055;
    ReadRegister1 = 5'd9; ReadRegister2 = 5'd9;
    #1;
    check("coll_pre_b0", rd1_b0, 32'h0000_00AA);
    check("coll_pre_b1", rd1_b1, 32'h0000_0055);
    tick();
    RegWrite = 1'b0;
    #1;
    check("coll_post_b0", rd1_b0, 32'h0000_0055);
    check("coll_post_b1", rd2_b1, 32'h0000_0055);

    write(5'd3, 32'h0000_0011);
    reset_n = 1'b0; RegWrite = 1'b1; WriteRegister = 5'd3; WriteData = 32'h0000_0022;
    ReadRegister1 = 5'd3; ReadRegister2 = 5'd3;
    #1;
    check("rst_wr_pre_b1", rd1_b1, 32'h0000_0011);
    tick();
    check("rst_wr_b0", rd1_b0, 32'h0);
    check("rst_wr_b1", rd2_b1, 32'h0);
    reset_n = 1'b1;
    tick();
    check("rst_wr_after", rd1_b0, 32'h0000_0022);

    // Randomized traffic with occasional reset, checked before and after each edge.
    for (int n = 0; n < 400; n++) begin
      reset_n       = ($urandom_range(0, 31) != 0);
      RegWrite      = $urandom_range(0, 1);
      WriteRegister = 5'($urandom_range(0, 31));
      WriteData     = $urandom;
      ReadRegister1 = ($urandom_range(0, 3) == 0) ? WriteRegister : 5'($urandom_range(0, 31));
      ReadRegister2 = ($urandom_range(0, 3) == 0) ? ReadRegister1 : 5'($urandom_range(0, 31));
      check_all("rand_pre");
      tick();
      check_all("rand_post");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
